// File: rtl/ps2_keyboard_receiver_if.sv
// Key-event handshake between the PS/2 receiver (master) and its consumer (slave).
interface ps2_keyboard_receiver_if;
    logic       key_valid;
    logic       key_ready;
    logic [6:0] key_ascii;
    logic [7:0] key_code;
    logic       key_release;
    logic       key_extended;
    logic       key_shift;

    modport master (
        output key_valid, key_ascii, key_code, key_release, key_extended, key_shift,
        input  key_ready
    );

    modport slave (
        input  key_valid, key_ascii, key_code, key_release, key_extended, key_shift,
        output key_ready
    );
endinterface

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit framing with odd parity,
// make/break/extended/shift tracking, ASCII translation and a FWFT event FIFO.
module ps2_keyboard_receiver #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    ps2_keyboard_receiver_if.master       key_if,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

    typedef struct packed {
        logic       rel;
        logic       ext;
        logic       shift;
        logic [7:0] code;
        logic [6:0] ascii;
    } key_event_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          clk_s;
    logic          dat_s;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_lvl_q;
    logic          filt_flip;
    logic          fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
        end
    end

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // The level flips on the FILTER_LEN-th consecutive differing sample.
    assign filt_flip = (clk_s != filt_lvl_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
    assign fall      = filt_flip && filt_lvl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_cnt_q <= '0;
            filt_lvl_q <= 1'b1;
        end else if (clk_s == filt_lvl_q) begin
            filt_cnt_q <= '0;
        end else if (filt_flip) begin
            filt_cnt_q <= '0;
            filt_lvl_q <= clk_s;
        end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    frame_state_e  state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          parity_err_q;
    logic          frame_err_q;
    logic          byte_ok;
    logic          tmo_hit;

    assign byte_ok = (state_q == STOP) && fall && dat_s && (^{shreg_q, par_q});
    assign tmo_hit = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (state_q == IDLE || fall) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (fall) begin
                        if (!dat_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (fall) begin
                        shreg_q   <= {dat_s, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (fall) begin
                        par_q   <= dat_s;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        state_q <= IDLE;
                        if (!byte_ok) begin
                            parity_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (tmo_hit) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code layer and translation
    // ------------------------------------------------------------------
    function automatic logic [6:0] to_ascii(input logic [7:0] code, input logic shift);
        logic [6:0] lower;
        logic [6:0] res;
        lower = '0;
        res   = '0;
        case (code)
            8'h1C: lower = 7'd97;   // a
            8'h32: lower = 7'd98;
            8'h21: lower = 7'd99;
            8'h23: lower = 7'd100;
            8'h24: lower = 7'd101;
            8'h2B: lower = 7'd102;
            8'h34: lower = 7'd103;
            8'h33: lower = 7'd104;
            8'h43: lower = 7'd105;
            8'h3B: lower = 7'd106;
            8'h42: lower = 7'd107;
            8'h4B: lower = 7'd108;
            8'h3A: lower = 7'd109;
            8'h31: lower = 7'd110;
            8'h44: lower = 7'd111;
            8'h4D: lower = 7'd112;
            8'h15: lower = 7'd113;
            8'h2D: lower = 7'd114;
            8'h1B: lower = 7'd115;
            8'h2C: lower = 7'd116;
            8'h3C: lower = 7'd117;
            8'h2A: lower = 7'd118;
            8'h1D: lower = 7'd119;
            8'h22: lower = 7'd120;
            8'h35: lower = 7'd121;
            8'h1A: lower = 7'd122;  // z
            8'h45: res = shift ? 7'd41 : 7'd48;
            8'h16: res = shift ? 7'd33 : 7'd49;
            8'h1E: res = shift ? 7'd64 : 7'd50;
            8'h26: res = shift ? 7'd35 : 7'd51;
            8'h25: res = shift ? 7'd36 : 7'd52;
            8'h2E: res = shift ? 7'd37 : 7'd53;
            8'h36: res = shift ? 7'd94 : 7'd54;
            8'h3D: res = shift ? 7'd38 : 7'd55;
            8'h3E: res = shift ? 7'd42 : 7'd56;
            8'h46: res = shift ? 7'd40 : 7'd57;
            8'h29: res = 7'd32;
            8'h5A: res = 7'd13;
            8'h66: res = 7'd8;
            default: res = '0;
        endcase
        if (lower != '0) begin
            res = shift ? (lower - 7'd32) : lower;
        end
        return res;
    endfunction

    logic       ext_q;
    logic       brk_q;
    logic       lshift_q;
    logic       rshift_q;
    logic       ev_valid_q;
    key_event_t ev_q;
    logic       shift_now;

    assign shift_now = lshift_q | rshift_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_q       <= '0;
        end else begin
            ev_valid_q <= 1'b0;
            if (byte_ok) begin
                case (shreg_q)
                    8'hE0: ext_q <= 1'b1;
                    8'hF0: brk_q <= 1'b1;
                    8'h12: begin
                        lshift_q <= ~brk_q;
                        ext_q    <= 1'b0;
                        brk_q    <= 1'b0;
                    end
                    8'h59: begin
                        rshift_q <= ~brk_q;
                        ext_q    <= 1'b0;
                        brk_q    <= 1'b0;
                    end
                    default: begin
                        ev_valid_q <= 1'b1;
                        ev_q.rel   <= brk_q;
                        ev_q.ext   <= ext_q;
                        ev_q.shift <= shift_now;
                        ev_q.code  <= shreg_q;
                        ev_q.ascii <= ext_q ? 7'd0 : to_ascii(shreg_q, shift_now);
                        ext_q      <= 1'b0;
                        brk_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    key_event_t    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          overflow_q;
    logic          full;
    logic          not_empty;
    logic          pop;
    logic          wr_en;
    key_event_t    head;

    assign full      = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign not_empty = (count_q != '0);
    assign pop       = not_empty && key_if.key_ready;
    // A pop frees the head slot in the same edge, so a full FIFO still takes the push.
    assign wr_en     = ev_valid_q && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= ev_valid_q && full && !pop;
            count_q    <= count_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= ev_q;
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign key_if.key_valid    = not_empty;
    assign key_if.key_ascii    = not_empty ? head.ascii : '0;
    assign key_if.key_code     = not_empty ? head.code  : '0;
    assign key_if.key_release  = not_empty && head.rel;
    assign key_if.key_extended = not_empty && head.ext;
    assign key_if.key_shift    = not_empty && head.shift;

    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Scoreboard bench for ps2_keyboard_receiver: directed PS/2 frames, queued expectations.
module tb_ps2_keyboard_receiver;

    localparam int unsigned FL    = 4;
    localparam int unsigned TMO   = 100;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned HALF  = 10;

    typedef struct packed {
        logic       rel;
        logic       ext;
        logic       shift;
        logic [7:0] code;
        logic [6:0] ascii;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic [3:0] fifo_count;

    ps2_keyboard_receiver_if kif ();

    ps2_keyboard_receiver #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .key_if     (kif),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    ev_t sb_q [$];
    int  checks   = 0;
    int  failures = 0;
    int  pe_rise = 0, pe_hi = 0, fe_rise = 0, fe_hi = 0, ov_rise = 0, ov_hi = 0;
    logic pe_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;
    ev_t got, want;

    // Monitor: compares every accepted head event with the scoreboard front.
    always @(negedge clk) begin
        if (reset === 1'b0 && kif.key_valid === 1'b1 && kif.key_ready === 1'b1) begin
            got = {kif.key_release, kif.key_extended, kif.key_shift, kif.key_code, kif.key_ascii};
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got code=%h ascii=%0d rel=%b ext=%b sh=%b, none expected",
                         got.code, got.ascii, got.rel, got.ext, got.shift);
            end else begin
                want = sb_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL event: got code=%h ascii=%0d rel=%b ext=%b sh=%b, expected code=%h ascii=%0d rel=%b ext=%b sh=%b",
                             got.code, got.ascii, got.rel, got.ext, got.shift,
                             want.code, want.ascii, want.rel, want.ext, want.shift);
                end
            end
        end
        pe_hi += int'(parity_err === 1'b1);
        fe_hi += int'(frame_err === 1'b1);
        ov_hi += int'(overflow === 1'b1);
        if (parity_err === 1'b1 && !pe_prev) pe_rise++;
        if (frame_err === 1'b1 && !fe_prev) fe_rise++;
        if (overflow === 1'b1 && !ov_prev) ov_rise++;
        pe_prev = (parity_err === 1'b1);
        fe_prev = (frame_err === 1'b1);
        ov_prev = (overflow === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic exp_ev(input logic rel, input logic ext, input logic sh,
                          input logic [7:0] code, input logic [6:0] ascii);
        ev_t e;
        e = {rel, ext, sh, code, ascii};
        sb_q.push_back(e);
    endtask

    // One PS/2 bit; optionally pulse key_ready one cycle so a pop meets the stop-bit push.
    task automatic ps2_bit(input logic b, input logic pop_here);
        ps2_dat = b;
        step(HALF);
        ps2_clk = 1'b0;
        if (pop_here) begin
            step(6);
            kif.key_ready = 1'b1;
            step(1);
            kif.key_ready = 1'b0;
            step(HALF - 7);
        end else begin
            step(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] b, input logic par, input logic stop, input logic pop_at_stop);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(stop, pop_at_stop);
        ps2_dat = 1'b1;
        step(HALF);
    endtask

    task automatic send(input logic [7:0] b);
        send_raw(b, ~^b, 1'b1, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        int unsigned n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            step(1);
            n++;
        end
        check(name, sb_q.size(), 0);
    endtask

    int pe0, fe0, ov0;
    logic [7:0] fill_codes [9];

    initial begin
        fill_codes[0] = 8'h1C; fill_codes[1] = 8'h32; fill_codes[2] = 8'h21;
        fill_codes[3] = 8'h23; fill_codes[4] = 8'h24; fill_codes[5] = 8'h2B;
        fill_codes[6] = 8'h34; fill_codes[7] = 8'h33; fill_codes[8] = 8'h43;

        reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; kif.key_ready = 1'b1;
        step(5);
        check("reset_valid", kif.key_valid, 0);
        check("reset_count", fifo_count, 0);
        check("reset_flags", {parity_err, frame_err, overflow}, 0);
        check("reset_head", {kif.key_ascii, kif.key_code, kif.key_release, kif.key_extended, kif.key_shift}, 0);
        reset = 1'b0;
        step(5);

        // Unshifted letter
        exp_ev(0, 0, 0, 8'h1C, 7'd97);
        send(8'h1C);
        wait_drain("unshifted_a");

        // Shift and break
        exp_ev(0, 0, 1, 8'h1C, 7'd65);
        exp_ev(1, 0, 1, 8'h1C, 7'd65);
        exp_ev(0, 0, 0, 8'h1C, 7'd97);
        send(8'h12); send(8'h1C);
        send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12);
        send(8'h1C);
        wait_drain("shift_break");

        // Extended keys, digits, specials, unmapped
        exp_ev(0, 1, 0, 8'h75, 7'd0);
        exp_ev(1, 1, 0, 8'h75, 7'd0);
        exp_ev(0, 0, 1, 8'h16, 7'd33);
        exp_ev(0, 0, 1, 8'h45, 7'd41);
        exp_ev(0, 0, 0, 8'h29, 7'd32);
        exp_ev(0, 0, 0, 8'h5A, 7'd13);
        exp_ev(0, 0, 0, 8'h66, 7'd8);
        exp_ev(0, 0, 0, 8'h45, 7'd48);
        exp_ev(0, 0, 0, 8'h05, 7'd0);
        exp_ev(0, 0, 1, 8'h4D, 7'd80);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h12); send(8'h16); send(8'h45); send(8'hF0); send(8'h12);
        send(8'h29); send(8'h5A); send(8'h66); send(8'h45); send(8'h05);
        send(8'h59); send(8'h4D); send(8'hF0); send(8'h59);
        wait_drain("ext_digits");

        // Error paths
        pe0 = pe_rise; fe0 = fe_rise;
        send_raw(8'h1C, 1'b1, 1'b1, 1'b0);
        step(10);
        check("bad_parity_pulse", pe_rise - pe0, 1);
        check("bad_parity_nopush", fifo_count, 0);
        send_raw(8'h1C, 1'b0, 1'b0, 1'b0);
        step(10);
        check("bad_stop_pulse", pe_rise - pe0, 2);
        ps2_bit(1'b1, 1'b0);
        step(HALF);
        check("bad_start_pulse", fe_rise - fe0, 1);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1, 1'b0);
        ps2_dat = 1'b1;
        step(TMO + 50);
        check("timeout_pulse", fe_rise - fe0, 2);
        exp_ev(0, 0, 0, 8'h1C, 7'd97);
        send(8'h1C);
        wait_drain("after_timeout");
        check("errors_no_parity_extra", pe_rise - pe0, 2);

        // FIFO fill, overflow, push-with-pop while full, drain
        ov0 = ov_rise;
        kif.key_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_ev(0, 0, 0, fill_codes[i], 7'(97 + i));
            send(fill_codes[i]);
        end
        step(10);
        check("fifo_full_count", fifo_count, 8);
        check("overflow_pulse", ov_rise - ov0, 1);
        exp_ev(0, 0, 0, 8'h3B, 7'd106);
        send_raw(8'h3B, ~^8'h3B, 1'b1, 1'b1);
        step(10);
        check("push_pop_full_count", fifo_count, 8);
        check("push_pop_no_overflow", ov_rise - ov0, 1);
        check("push_pop_one_popped", sb_q.size(), 8);
        kif.key_ready = 1'b1;
        step(7);
        check("drain_7", fifo_count, 1);
        step(1);
        check("drain_8", fifo_count, 0);
        wait_drain("drain_order");

        // Glitch shorter than the filter
        fe0 = fe_rise;
        ps2_clk = 1'b0;
        step(FL - 2);
        ps2_clk = 1'b1;
        step(20);
        check("glitch_no_fall", fe_rise - fe0, 0);
        exp_ev(0, 0, 0, 8'h1C, 7'd97);
        send(8'h1C);
        wait_drain("after_glitch");

        // Reset mid-frame with shift held
        send(8'h12);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0], 1'b0);
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        ps2_dat = 1'b1;
        step(5);
        check("reset_mid_count", fifo_count, 0);
        exp_ev(0, 0, 0, 8'h1C, 7'd97);
        send(8'h1C);
        wait_drain("after_reset");
        check("reset_no_frame_err", fe_rise - fe0, 0);

        step(10);
        check("parity_err_width", pe_hi, pe_rise);
        check("frame_err_width", fe_hi, fe_rise);
        check("overflow_width", ov_hi, ov_rise);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not complete, pending=%0d", sb_q.size());
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_keyboard_receiver.md
# ps2_keyboard_receiver

System-clock-synchronous PS/2 keyboard receiver. It oversamples and glitch-filters the keyboard clock and data pins, frames 11-bit PS/2 packets and checks their parity. It tracks make/break, extended-code and shift state, and translates scan codes to ASCII with case. Decoded key events are queued in a parametrised FIFO behind a valid/ready handshake that the text-editor core consumes.

## Interface
- FILTER_LEN, 4: consecutive identical samples required before the filtered PS/2 clock changes level (≥2).
- TIMEOUT_CYCLES, 50000: clk cycles without a PS/2 falling edge before a partial frame is aborted.
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- clk  in  1  system clock; one clock only. Reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw keyboard clock; asynchronous to clk.
- ps2_dat  in  1  raw keyboard data; asynchronous to clk.
- key_valid  out  1  FIFO head holds an event.
- key_ready  in  1  consumer accepts the head event.
- key_ascii  out  7  ASCII value of the head event; 0 if the key is unmapped.
- key_code  out  8  raw scan code of the head event.
- key_release  out  1  head event is a break (F0-prefixed).
- key_extended  out  1  head event was E0-prefixed.
- key_shift  out  1  shift state when the head event was decoded.
- parity_err  out  1  one-cycle pulse on a parity or stop-bit failure.
- frame_err  out  1  one-cycle pulse on a bad start bit or a timeout abort.
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Input conditioning:** ps2_clk and ps2_dat each pass through a 2-FF synchroniser. The filtered clock takes the synchronised level only after FILTER_LEN equal consecutive samples. A falling edge of the filtered clock is a one-cycle `fall` strobe; ps2_dat is sampled in that cycle.
- **Frame FSM.** States IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, dat=0 moves to DATA with bit count 0. dat=1 pulses frame_err and stays in IDLE.
  - DATA: shifts dat in LSB first. After the 8th bit the FSM goes to PARITY.
  - PARITY: stores dat and goes to STOP.
  - STOP: the frame is accepted only if the 8 data bits plus the parity bit have an odd number of ones and dat=1. Otherwise parity_err pulses and the byte is discarded. The FSM always returns to IDLE.
- **Timeout:** in any non-IDLE state a counter clears on each `fall`. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, the partial byte is dropped and frame_err pulses.
- **Scan-code layer.** For each accepted byte:
  - E0 sets the ext flag.
  - F0 sets the brk flag.
  - 12 or 59 sets or clears the left/right shift bit (brk selects clear), then clears both flags. No event is produced.
  - Any other byte produces an event {brk, ext, shift = lshift|rshift, code, ascii}, then clears both flags.
- **Translation** (ext=0 only; ext=1 always gives ascii 0).
  - Letters: lowercase 97–122 unshifted, uppercase 65–90 shifted.
  - Digits 0–9: '0'–'9' unshifted; shifted gives `)!@#$%^&*(` respectively.
  - 29 → 32 (space). 5A → 13. 66 → 8. Any other code → 0.
- **FIFO:** first-word fall-through, with key_* driven from the head.
  - Push when an event is produced. Pop when key_valid && key_ready.
  - Push while full without a pop: the event is dropped and overflow pulses.
  - Push while full with a simultaneous pop: the push is accepted and the count is unchanged.
  - Push and pop while empty: not possible, since key_valid=0.
- **Reset:** returns the FSM to IDLE and clears the bit counter, timeout counter, ext, brk and shift state, and the FIFO pointers. All outputs go to 0; the filter's stable level resets to 1.

## Timing
- A pin edge becomes a `fall` strobe 2 + FILTER_LEN clk cycles later, provided the pin is stable.
- The byte is accepted in the cycle of the stop-bit `fall` (cycle N). The event is registered at N+1 and written to the FIFO at N+1. key_valid rises at N+2 when the FIFO was empty.
- Pop takes effect at the clock edge where key_valid && key_ready. The next head entry, or key_valid=0, is visible in the following cycle.
- parity_err, frame_err and overflow are each high for exactly one cycle.
- Reset asserted mid-frame discards the frame. The first `fall` after reset is treated as a start bit.

## Test plan
- **Unshifted letter.** Send frame 1C (parity 0). Expect key_valid at N+2 with ascii 97, code 1C, release=0, extended=0, shift=0.
- **Shift and break.** Send 12, 1C, F0 1C, F0 12, 1C. Expect events in this order:
  - ascii 65, shift=1.
  - ascii 65, release=1, shift=1.
  - ascii 97, shift=0.
  - Neither shift byte produces an event.
- **Extended key and digits.**
  - E0 75 → code 75, extended=1, ascii 0.
  - 12 16 → ascii 33 ('!').
- **Error paths.**
  - 1C with parity 1 → parity_err pulse and no push.
  - Stop bit 0 → parity_err pulse.
  - Start bit 1 → frame_err pulse.
  - 5 data bits then an idle clock → frame_err after TIMEOUT_CYCLES. The next clean 1C still decodes to 97.
- **FIFO.** Hold key_ready=0 and send 9 make codes. Expect fifo_count=8 and one overflow pulse; the 9th event is dropped. Then raise key_ready and check that the 8 events drain in order, one per cycle. Also check that a push coinciding with a pop while full keeps the count at 8.
- **Glitch and reset.**
  - A ps2_clk low glitch shorter than FILTER_LEN cycles produces no `fall`.
  - Reset asserted after 4 data bits clears state; the next full 1C decodes correctly.
